dac_seq_ctrl: RTL

Two-channel DAC write sequencer that owns the shared 14-bit DAC bus and its `dac_sel`/`dac_wrt` strobes. It accepts independent valid/ready sample streams for channels A and B, buffers each in a small FIFO, and alternates A/B write slots in a fixed frame. Each sample is converted to the DAC pin format: MSB kept, lower 13 bits inverted. The block sits between the generator/ASG outputs and the DAC pin drivers in the `dac_clk` domain.

---
 rtl/dac_seq_pkg.sv | 24 ++
 rtl/dac_seq_ctrl_if.sv | 31 +++
 rtl/dac_seq_fifo.sv | 56 +++++
 rtl/dac_seq_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg
//   Shared definitions for the two-channel DAC write sequencer:
//   sequencer state encoding, default sample width, the idle/reset
//   DAC code and the pin-format conversion.
package dac_seq_pkg;

    localparam int DAC_DW = 14;

    // fmt(0): the code the DAC bus shows after reset.
    localparam logic [DAC_DW-1:0] DAC_RST_CODE = 14'h1FFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLOT_A = 2'd1,
        SLOT_B = 2'd2
    } seq_state_t;

    // Two's complement sample to DAC pin format: MSB kept, lower bits
    // inverted. Applying it twice returns the original sample.
    function automatic logic [DAC_DW-1:0] fmt(input logic [DAC_DW-1:0] d);
        return {d[DAC_DW-1], ~d[DAC_DW-2:0]};
    endfunction

endpackage

// File: rtl/dac_seq_ctrl_if.sv
// dac_seq_ctrl_if
//   Groups the two sample streams and the shared DAC bus.
//   cha_* / chb_* : channel A / B sample streams (dat, vld, rdy)
//   dac_dat       : DAC bus data in pin format
//   dac_sel       : channel select, 0 = A, 1 = B
//   dac_wrt       : write strobe, active-low
//   Modports: slave  = sequencer side (consumes streams, drives DAC bus)
//             master = environment side (produces streams, observes bus)
interface dac_seq_ctrl_if #(
    parameter int DW = 14
);
    logic [DW-1:0] cha_dat;
    logic          cha_vld;
    logic          cha_rdy;
    logic [DW-1:0] chb_dat;
    logic          chb_vld;
    logic          chb_rdy;
    logic [DW-1:0] dac_dat;
    logic          dac_sel;
    logic          dac_wrt;

    modport slave (
        input  cha_dat, cha_vld, chb_dat, chb_vld,
        output cha_rdy, chb_rdy, dac_dat, dac_sel, dac_wrt
    );

    modport master (
        output cha_dat, cha_vld, chb_dat, chb_vld,
        input  cha_rdy, chb_rdy, dac_dat, dac_sel, dac_wrt
    );
endinterface

// File: rtl/dac_seq_fifo.sv
// dac_seq_fifo
//   Small synchronous FIFO, one per DAC channel.
//   clk, srst        : clock, synchronous active-high reset (empties FIFO)
//   push, push_dat   : write request and data; accepted when rdy is high
//   rdy              : not full and not in reset (no bypass on full)
//   pop              : read request; ignored when empty
//   empty, head      : status and oldest entry, valid while not empty
//   The head is read straight from the storage array so the sequencer can
//   pop and use it on the same edge; a sample written at edge k is
//   visible as head from edge k onwards.
module dac_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 14
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    output logic          rdy,
    input  logic          pop,
    output logic          empty,
    output logic [DW-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rdy     = ~full & ~srst;
    assign do_push = push & rdy;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/dac_seq_ctrl.sv
// dac_seq_ctrl
//   Two-channel DAC write sequencer. Buffers channel A/B samples in
//   per-channel FIFOs and writes them to the shared DAC bus in a fixed
//   two-cycle frame (A slot then B slot), converting to pin format.
//   Ports:
//     dac_clk_i, dac_rst_i : clock, synchronous active-high reset
//     en_i                 : run enable (registered before use, frames atomic)
//     clr_i                : clears sticky underrun flags (and counters)
//     bus                  : dac_seq_ctrl_if.slave - sample streams + DAC bus
//     unf_o                : sticky underrun flags, bit 0 = A, bit 1 = B
//     unf_cnt_a_o/_b_o     : saturating underrun counters (optional)
//   Build option: define DAC_SEQ_UNF_CNT_EN to add the underrun counters.
module dac_seq_ctrl
    import dac_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DW         = DAC_DW
) (
    input  logic                dac_clk_i,
    input  logic                dac_rst_i,
    input  logic                en_i,
    input  logic                clr_i,
    dac_seq_ctrl_if.slave       bus,
    output logic [1:0]          unf_o
`ifdef DAC_SEQ_UNF_CNT_EN
    ,
    output logic [15:0]         unf_cnt_a_o,
    output logic [15:0]         unf_cnt_b_o
`endif
);
    seq_state_t         state_reg, state_next;
    logic               en_reg;
    logic [DW-1:0]      dat_reg, dat_next;
    logic               sel_reg, sel_next;
    logic               wrt_reg, wrt_next;
    logic [1:0]         unf_reg, unf_next;
    logic [1:0][DW-1:0] last_reg, last_next;
    logic [1:0]         unf_evt;
    logic [1:0]         pop;
    logic [1:0]         empty;
    logic [1:0]         rdy;
    logic [DW-1:0]      head [2];
    logic               slot_ch;

    // Index 0 = channel A, index 1 = channel B.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        dac_seq_fifo #(
            .DEPTH (FIFO_DEPTH),
            .DW    (DW)
        ) u_fifo (
            .clk      (dac_clk_i),
            .srst     (dac_rst_i),
            .push     ((gi == 0) ? bus.cha_vld : bus.chb_vld),
            .push_dat ((gi == 0) ? bus.cha_dat : bus.chb_dat),
            .rdy      (rdy[gi]),
            .pop      (pop[gi]),
            .empty    (empty[gi]),
            .head     (head[gi])
        );
    end

    assign bus.cha_rdy = rdy[0];
    assign bus.chb_rdy = rdy[1];
    assign bus.dac_dat = dat_reg;
    assign bus.dac_sel = sel_reg;
    assign bus.dac_wrt = wrt_reg;
    assign unf_o       = unf_reg;

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_reg <= IDLE;
            en_reg    <= 1'b0;
            dat_reg   <= DAC_RST_CODE;
            sel_reg   <= 1'b0;
            wrt_reg   <= 1'b1;
            unf_reg   <= 2'b00;
            last_reg  <= '0;
        end else begin
            state_reg <= state_next;
            en_reg    <= en_i;
            dat_reg   <= dat_next;
            sel_reg   <= sel_next;
            wrt_reg   <= wrt_next;
            unf_reg   <= unf_next;
            last_reg  <= last_next;
        end
    end

    // Slot outputs are computed for the state being entered so they are
    // registered on the same edge as the transition.
    always_comb begin
        state_next = state_reg;
        dat_next   = dat_reg;
        sel_next   = sel_reg;
        wrt_next   = wrt_reg;
        last_next  = last_reg;
        pop        = 2'b00;
        unf_evt    = 2'b00;
        slot_ch    = 1'b0;

        case (state_reg)
            IDLE:    if (en_reg) state_next = SLOT_A;
            SLOT_A:  state_next = SLOT_B;
            SLOT_B:  state_next = en_reg ? SLOT_A : IDLE;
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE) begin
            wrt_next = 1'b1;
        end else begin
            slot_ch  = (state_next == SLOT_B);
            sel_next = slot_ch;
            wrt_next = 1'b0;
            if (!empty[slot_ch]) begin
                pop[slot_ch]       = 1'b1;
                dat_next           = fmt(head[slot_ch]);
                last_next[slot_ch] = head[slot_ch];
            end else begin
                // Underrun: repeat the last sample written on this channel.
                dat_next         = fmt(last_reg[slot_ch]);
                unf_evt[slot_ch] = 1'b1;
            end
        end

        // A new underrun in the clearing cycle still leaves its flag set.
        unf_next = (clr_i ? 2'b00 : unf_reg) | unf_evt;
    end

`ifdef DAC_SEQ_UNF_CNT_EN
    logic [1:0][15:0] unf_cnt_reg;

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            unf_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (clr_i)
                    unf_cnt_reg[i] <= {15'd0, unf_evt[i]};
                else if (unf_evt[i] && (unf_cnt_reg[i] != 16'hFFFF))
                    unf_cnt_reg[i] <= unf_cnt_reg[i] + 16'd1;
            end
        end
    end

    assign unf_cnt_a_o = unf_cnt_reg[0];
    assign unf_cnt_b_o = unf_cnt_reg[1];
`endif

endmodule
